// File: rtl/pmod_link_bridge.sv
// rtl/pmod_link_bridge.sv - Pmod pin bridge, reset sequencer, enable debounce and LED view for the hashing core
//
// Purpose:
//   Board-side glue between the Pmod headers and the hashing core.
//   - Inbound data/ctrl are carried through SYNC_STAGES flops into the core.
//   - Outbound hash/ctrl are carried through OUT_STAGES flops to the pins.
//   - The core reset is released only after the PLL has been locked for
//     LOCK_CYCLES cycles plus a RST_HOLD margin.
//   - The enable switch is debounced over DEB_CYCLES.
//   - The core output-enable is checked against EXP_OE while the core runs
//     (sticky error).
//   - hash_v words are counted, and a paged LED view is shown.
//
// Optional feature macro: BRIDGE_LOOPBACK_EN
//   When defined, a synchronised loopback_i selects core_data_o and
//   {data_ctrl[0], 1'b1} as the source of the outbound pipeline.
//   While loopback is selected, word_cnt is frozen.
//
// Ports:
//   clk              in   core clock
//   rst_async        in   asynchronous active-high reset
//   pll_lock_i       in   PLL locked (asynchronous)
//   ena_sw_i         in   raw enable switch
//   led_page_i       in   LED page select (raw switch)
//   loopback_i       in   loopback request (only used with BRIDGE_LOOPBACK_EN)
//   pin_data_i       in   Pmod data pins
//   pin_ctrl_i       in   Pmod ctrl pins {loopback_ctrl[1:0], data_ctrl[2:0]}
//   pin_hash_o       out  Pmod hash pins
//   pin_hash_ctrl_o  out  Pmod hash ctrl pins {hash_v, ready}
//   core_data_o      out  data to the core
//   core_ctrl_o      out  ctrl to the core
//   core_hash_i      in   hash from the core
//   core_hash_ctrl_i in   hash ctrl from the core {hash_v, ready}
//   core_oe_i        in   core output-enable vector
//   core_rst_n_o     out  core active-low reset
//   core_ena_o       out  debounced enable
//   error_o          out  sticky output-enable error
//   led_o            out  paged debug LEDs

module pmod_link_bridge #(
  parameter int         DATA_W      = 8,
  parameter int         CTRL_IN_W   = 5,
  parameter int         CTRL_OUT_W  = 2,
  parameter int         SYNC_STAGES = 2,
  parameter int         OUT_STAGES  = 2,
  parameter int         LOCK_CYCLES = 1024,
  parameter int         RST_HOLD    = 16,
  parameter int         DEB_CYCLES  = 65536,
  parameter logic [7:0] EXP_OE      = 8'h88,
  parameter int         LED_W       = 16
) (
  input  logic                  clk,
  input  logic                  rst_async,
  input  logic                  pll_lock_i,
  input  logic                  ena_sw_i,
  input  logic [1:0]            led_page_i,
  input  logic                  loopback_i,
  input  logic [DATA_W-1:0]     pin_data_i,
  input  logic [CTRL_IN_W-1:0]  pin_ctrl_i,
  output logic [DATA_W-1:0]     pin_hash_o,
  output logic [CTRL_OUT_W-1:0] pin_hash_ctrl_o,
  output logic [DATA_W-1:0]     core_data_o,
  output logic [CTRL_IN_W-1:0]  core_ctrl_o,
  input  logic [DATA_W-1:0]     core_hash_i,
  input  logic [CTRL_OUT_W-1:0] core_hash_ctrl_i,
  input  logic [7:0]            core_oe_i,
  output logic                  core_rst_n_o,
  output logic                  core_ena_o,
  output logic                  error_o,
  output logic [LED_W-1:0]      led_o
);

  localparam int LOCK_MAX = (LOCK_CYCLES > RST_HOLD) ? LOCK_CYCLES : RST_HOLD;
  localparam int CNT_W    = $clog2(LOCK_MAX + 1);
  localparam int DEB_W    = $clog2(DEB_CYCLES + 1);

  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(RST_HOLD - 1);
  localparam logic [DEB_W-1:0] DEB_LAST  = DEB_W'(DEB_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_WAIT_LOCK = 2'd0,
    ST_HOLD      = 2'd1,
    ST_RUN       = 2'd2
  } state_t;

  // Two-flop synchroniser for the slow asynchronous controls:
  // bit 0 = pll lock, bit 1 = enable switch, bits 3:2 = LED page.
  logic [3:0] meta_q, meta_d;
  logic [3:0] sync_q, sync_d;

  always_comb begin
    meta_d = {led_page_i, ena_sw_i, pll_lock_i};
    sync_d = meta_q;
  end

  always_ff @(posedge clk or posedge rst_async) begin
    if (rst_async) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  logic       lock_s;
  logic       ena_s;
  logic [1:0] page_s;

  assign lock_s = sync_q[0];
  assign ena_s  = sync_q[1];
  assign page_s = sync_q[3:2];

  // Loopback select: synchronised only when the feature is built in.
  logic lb_s;

`ifdef BRIDGE_LOOPBACK_EN
  logic lb_meta_q, lb_meta_d;
  logic lb_sync_q, lb_sync_d;

  always_comb begin
    lb_meta_d = loopback_i;
    lb_sync_d = lb_meta_q;
  end

  always_ff @(posedge clk or posedge rst_async) begin
    if (rst_async) begin
      lb_meta_q <= 1'b0;
      lb_sync_q <= 1'b0;
    end else begin
      lb_meta_q <= lb_meta_d;
      lb_sync_q <= lb_sync_d;
    end
  end

  assign lb_s = lb_sync_q;
`else
  logic unused_loopback;
  assign unused_loopback = loopback_i;
  assign lb_s = 1'b0;
`endif

  // Inbound pipeline: the last stage drives the core directly.
  logic [DATA_W-1:0]    in_data_q [SYNC_STAGES];
  logic [DATA_W-1:0]    in_data_d [SYNC_STAGES];
  logic [CTRL_IN_W-1:0] in_ctrl_q [SYNC_STAGES];
  logic [CTRL_IN_W-1:0] in_ctrl_d [SYNC_STAGES];

  always_comb begin
    in_data_d[0] = pin_data_i;
    in_ctrl_d[0] = pin_ctrl_i;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      in_data_d[i] = in_data_q[i-1];
      in_ctrl_d[i] = in_ctrl_q[i-1];
    end
  end

  always_ff @(posedge clk or posedge rst_async) begin
    if (rst_async) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        in_data_q[i] <= '0;
        in_ctrl_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        in_data_q[i] <= in_data_d[i];
        in_ctrl_q[i] <= in_ctrl_d[i];
      end
    end
  end

  assign core_data_o = in_data_q[SYNC_STAGES-1];
  assign core_ctrl_o = in_ctrl_q[SYNC_STAGES-1];

  // Outbound pipeline source: core outputs, or the inbound data in loopback.
  logic [DATA_W-1:0]     hash_src;
  logic [CTRL_OUT_W-1:0] hctrl_src;

  always_comb begin
    hash_src  = core_hash_i;
    hctrl_src = core_hash_ctrl_i;
    if (lb_s) begin
      hash_src  = core_data_o;
      hctrl_src = CTRL_OUT_W'({core_ctrl_o[0], 1'b1});
    end
  end

  logic [DATA_W-1:0]     out_hash_q  [OUT_STAGES];
  logic [DATA_W-1:0]     out_hash_d  [OUT_STAGES];
  logic [CTRL_OUT_W-1:0] out_hctrl_q [OUT_STAGES];
  logic [CTRL_OUT_W-1:0] out_hctrl_d [OUT_STAGES];

  always_comb begin
    out_hash_d[0]  = hash_src;
    out_hctrl_d[0] = hctrl_src;
    for (int i = 1; i < OUT_STAGES; i++) begin
      out_hash_d[i]  = out_hash_q[i-1];
      out_hctrl_d[i] = out_hctrl_q[i-1];
    end
  end

  always_ff @(posedge clk or posedge rst_async) begin
    if (rst_async) begin
      for (int i = 0; i < OUT_STAGES; i++) begin
        out_hash_q[i]  <= '0;
        out_hctrl_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < OUT_STAGES; i++) begin
        out_hash_q[i]  <= out_hash_d[i];
        out_hctrl_q[i] <= out_hctrl_d[i];
      end
    end
  end

  assign pin_hash_o      = out_hash_q[OUT_STAGES-1];
  assign pin_hash_ctrl_o = out_hctrl_q[OUT_STAGES-1];

  // Reset sequencer. One counter serves both the lock qualification and the
  // hold phase since they never run at the same time.
  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             core_rst_n_q;
  logic [7:0]       loss_q;

  always_ff @(posedge clk or posedge rst_async) begin
    if (rst_async) begin
      state_q      <= ST_WAIT_LOCK;
      cnt_q        <= '0;
      core_rst_n_q <= 1'b0;
      loss_q       <= 8'h00;
    end else begin
      case (state_q)
        ST_WAIT_LOCK: begin
          if (!lock_s) begin
            cnt_q <= '0;
          end else if (cnt_q == LOCK_LAST) begin
            state_q <= ST_HOLD;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_HOLD: begin
          if (!lock_s) begin
            state_q <= ST_WAIT_LOCK;
            cnt_q   <= '0;
          end else if (cnt_q == HOLD_LAST) begin
            state_q      <= ST_RUN;
            cnt_q        <= '0;
            core_rst_n_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_RUN: begin
          if (!lock_s) begin
            state_q      <= ST_WAIT_LOCK;
            cnt_q        <= '0;
            core_rst_n_q <= 1'b0;
            if (loss_q != 8'hFF) begin
              loss_q <= loss_q + 1'b1;
            end
          end
        end
        default: begin
          state_q      <= ST_WAIT_LOCK;
          cnt_q        <= '0;
          core_rst_n_q <= 1'b0;
        end
      endcase
    end
  end

  assign core_rst_n_o = core_rst_n_q;

  // Enable debounce: the counter only runs while the synchronised switch
  // disagrees with the accepted value, so any short excursion restarts it.
  logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;
  logic             ena_q, ena_d;

  always_comb begin
    deb_cnt_d = deb_cnt_q;
    ena_d     = ena_q;
    if (ena_s == ena_q) begin
      deb_cnt_d = '0;
    end else if (deb_cnt_q == DEB_LAST) begin
      ena_d     = ~ena_q;
      deb_cnt_d = '0;
    end else begin
      deb_cnt_d = deb_cnt_q + 1'b1;
    end
  end

  // Sticky OE error, word counter and LED view.
  logic              error_q, error_d;
  logic [15:0]       word_cnt_q, word_cnt_d;
  logic [LED_W-1:0]  led_q, led_d;

  always_comb begin
    error_d = error_q | (core_rst_n_q & (core_oe_i != EXP_OE));

    word_cnt_d = word_cnt_q;
    if (!core_rst_n_q) begin
      word_cnt_d = 16'h0000;
    end else if ((state_q == ST_RUN) && core_hash_ctrl_i[1] && !lb_s) begin
      word_cnt_d = word_cnt_q + 16'h0001;
    end

    case (page_s)
      2'd0:    led_d = LED_W'({core_ctrl_o, core_hash_ctrl_i, error_q, ena_q,
                               core_rst_n_q, state_q});
      2'd1:    led_d = LED_W'({core_hash_i, core_data_o});
      2'd2:    led_d = LED_W'(word_cnt_q);
      default: led_d = LED_W'({8'h00, loss_q});
    endcase
  end

  always_ff @(posedge clk or posedge rst_async) begin
    if (rst_async) begin
      deb_cnt_q  <= '0;
      ena_q      <= 1'b0;
      error_q    <= 1'b0;
      word_cnt_q <= 16'h0000;
      led_q      <= '0;
    end else begin
      deb_cnt_q  <= deb_cnt_d;
      ena_q      <= ena_d;
      error_q    <= error_d;
      word_cnt_q <= word_cnt_d;
      led_q      <= led_d;
    end
  end

  assign core_ena_o = ena_q;
  assign error_o    = error_q;
  assign led_o      = led_q;

endmodule
